// File: rtl/proj_adder_pipe_if.sv
// Operand/result bundle for proj_adder_pipe: the producer drives en, a and b,
// and the adder returns the registered sum z.
interface proj_adder_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] z;

  // Producer side: drives operands and the advance enable.
  modport master (
    output en,
    output a,
    output b,
    input  z
  );

  // Adder side: consumes operands and returns the sum.
  modport slave (
    input  en,
    input  a,
    input  b,
    output z
  );

endinterface : proj_adder_pipe_if

// File: rtl/proj_adder_pipe.sv
// 3-stage, enable-gated, modulo-2^WIDTH adder z = a + b.
// Stage 1 registers the operands, stage 2 adds the low SPLIT bits and keeps the
// carry, and stage 3 adds the high segment plus that carry. Splitting the add
// this way keeps each stage's carry chain short. en=0 freezes every stage; a
// synchronous reset clears every stage and takes priority over en.
// SPLIT must satisfy 1 <= SPLIT < WIDTH.
module proj_adder_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SPLIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  proj_adder_pipe_if.slave  bus
);

  localparam int unsigned HI = WIDTH - SPLIT;

  // Stage 1: captured operands
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  // Stage 2: low-segment sum, its carry, and the high segments passed along
  logic [SPLIT-1:0] lo_q, lo_d;
  logic             c_lo_q, c_lo_d;
  logic [HI-1:0]    a_hi_q, a_hi_d;
  logic [HI-1:0]    b_hi_q, b_hi_d;

  // Stage 3: final result
  logic [WIDTH-1:0] z_q, z_d;

  // Intermediate sums
  logic [SPLIT:0]   lo_sum;
  logic [HI-1:0]    hi_sum;

  // Stage 1 next state: sample the operands
  always_comb begin
    a_d = bus.a;
    b_d = bus.b;
  end

  // Stage 2 next state: low-segment add with carry out, forward the high halves
  always_comb begin
    lo_sum = {1'b0, a_q[SPLIT-1:0]} + {1'b0, b_q[SPLIT-1:0]};
    lo_d   = lo_sum[SPLIT-1:0];
    c_lo_d = lo_sum[SPLIT];
    a_hi_d = a_q[WIDTH-1:SPLIT];
    b_hi_d = b_q[WIDTH-1:SPLIT];
  end

  // Stage 3 next state: high-segment add with the low carry; MSB carry is dropped
  always_comb begin
    hi_sum = a_hi_q + b_hi_q + HI'(c_lo_q);
    z_d    = {hi_sum, lo_q};
  end

  // Pipeline registers: reset clears all stages, en=0 holds all stages
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      lo_q   <= '0;
      c_lo_q <= 1'b0;
      a_hi_q <= '0;
      b_hi_q <= '0;
      z_q    <= '0;
    end else if (bus.en) begin
      a_q    <= a_d;
      b_q    <= b_d;
      lo_q   <= lo_d;
      c_lo_q <= c_lo_d;
      a_hi_q <= a_hi_d;
      b_hi_q <= b_hi_d;
      z_q    <= z_d;
    end
  end

  // Result is taken straight from the stage-3 flop
  assign bus.z = z_q;

endmodule : proj_adder_pipe

// File: tb/tb_proj_adder_pipe.sv
// Directed and random checks for proj_adder_pipe (WIDTH=8, SPLIT=4).
module tb_proj_adder_pipe;

  logic clk;
  logic reset;

  int unsigned n_checks;
  int unsigned n_errors;

  proj_adder_pipe_if #(.WIDTH(8)) bus_if ();

  proj_adder_pipe #(
    .WIDTH (8),
    .SPLIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, then settle past the edge before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end
  endtask

  // Hard bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] cv_a   [4] = '{8'h0F, 8'hFF, 8'h80, 8'hFF};
  logic [7:0] cv_b   [4] = '{8'h01, 8'h01, 8'h80, 8'hFF};
  logic [7:0] cv_z   [4] = '{8'h10, 8'h00, 8'h00, 8'hFE};
  logic [7:0] st_a   [3] = '{8'h10, 8'h30, 8'hF0};
  logic [7:0] st_b   [3] = '{8'h20, 8'h40, 8'h20};
  logic [7:0] st_z   [3] = '{8'h30, 8'h70, 8'h10};

  initial begin
    logic [7:0] exp_z;
    logic [7:0] ra, rb;
    logic       ren;

    n_checks = 0;
    n_errors = 0;

    // Reset held for 2 cycles with operands present
    reset     = 1'b1;
    bus_if.en = 1'b1;
    bus_if.a  = 8'h5A;
    bus_if.b  = 8'h33;
    tick();
    check_eq("reset_c1", bus_if.z, 8'h00);
    tick();
    check_eq("reset_c2", bus_if.z, 8'h00);
    reset = 1'b0;
    tick();
    check_eq("post_reset_c1", bus_if.z, 8'h00);
    tick();
    check_eq("post_reset_c2", bus_if.z, 8'h00);
    tick();
    check_eq("post_reset_c3", bus_if.z, 8'h8D);

    // Basic add, held 5 cycles
    bus_if.a = 8'h12;
    bus_if.b = 8'h34;
    for (int unsigned k = 1; k <= 5; k++) begin
      tick();
      if (k >= 3) check_eq($sformatf("basic_c%0d", k), bus_if.z, 8'h46);
    end

    // Cross-segment carry and wrap-around
    for (int unsigned i = 0; i < 4; i++) begin
      bus_if.a = cv_a[i];
      bus_if.b = cv_b[i];
      tick(); tick(); tick();
      check_eq($sformatf("carry_%0d", i), bus_if.z, cv_z[i]);
    end

    // Stall: one enabled load, then 4 frozen cycles with changed operands
    bus_if.a = 8'h01;
    bus_if.b = 8'h02;
    tick();
    check_eq("stall_load", bus_if.z, 8'hFE);
    bus_if.en = 1'b0;
    bus_if.a  = 8'hAA;
    bus_if.b  = 8'h11;
    for (int unsigned k = 1; k <= 4; k++) begin
      tick();
      check_eq($sformatf("stall_hold_c%0d", k), bus_if.z, 8'hFE);
    end
    bus_if.en = 1'b1;
    tick();
    check_eq("stall_resume_c1", bus_if.z, 8'hFE);
    tick();
    check_eq("stall_resume_c2", bus_if.z, 8'h03);
    tick();
    check_eq("stall_resume_c3", bus_if.z, 8'hBB);

    // Streaming back-to-back pairs
    for (int unsigned k = 1; k <= 5; k++) begin
      if (k <= 3) begin
        bus_if.a = st_a[k-1];
        bus_if.b = st_b[k-1];
      end
      tick();
      if (k >= 3) check_eq($sformatf("stream_%0d", k - 3), bus_if.z, st_z[k-3]);
    end

    // Reset mid-stream, then with en=0 to show reset wins over the stall
    bus_if.a = 8'h21;
    bus_if.b = 8'h43;
    tick();
    reset = 1'b1;
    tick();
    check_eq("midreset", bus_if.z, 8'h00);
    bus_if.en = 1'b0;
    tick();
    check_eq("reset_over_en0", bus_if.z, 8'h00);
    reset     = 1'b0;
    bus_if.en = 1'b1;
    tick();
    check_eq("midreset_flush_c1", bus_if.z, 8'h00);
    tick();
    check_eq("midreset_flush_c2", bus_if.z, 8'h00);
    tick();
    check_eq("midreset_refill", bus_if.z, 8'h64);
    exp_z = 8'h64;

    // Random pairs, en random, each held 5 cycles
    for (int unsigned i = 0; i < 64; i++) begin
      ra  = 8'($urandom_range(255));
      rb  = 8'($urandom_range(255));
      ren = 1'($urandom_range(1));
      bus_if.a  = ra;
      bus_if.b  = rb;
      bus_if.en = ren;
      for (int unsigned k = 0; k < 5; k++) tick();
      if (ren) exp_z = ra + rb;
      check_eq($sformatf("rand_%0d", i), bus_if.z, exp_z);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_proj_adder_pipe
